bcd_7seg_mux_driver: RTL and testbench

BCD_7SEG_MUX_DRIVER -- requirements
Module: bcd_7seg_mux_driver

---
 rtl/bcd_7seg_mux_driver.sv | 103 ++++++++++
 tb/tb_bcd_7seg_mux_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_7seg_mux_driver.sv
// Two-digit multiplexed BCD-to-7-segment driver with latched digits and a non-BCD error flag.
// Optional leading-zero blanking of the tens digit is built when LEADING_ZERO_BLANK_EN is defined.
module bcd_7seg_mux_driver #(
  parameter int REFRESH_DIV = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] high,
  input  logic [3:0] low,
  input  logic       load,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    dh_q, dh_d;
  logic [3:0]    dl_q, dl_d;
  logic          err_q, err_d;
  logic [3:0]    sel_digit;
  logic [6:0]    seg_raw;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    dh_d    = dh_q;
    dl_d    = dl_q;
    err_d   = err_q;

    // The digit switches on the same edge the refresh counter wraps.
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      state_d = (state_q == ST_LOW) ? ST_HIGH : ST_LOW;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (load) begin
      dh_d  = high;
      dl_d  = low;
      err_d = (high > 4'd9) | (low > 4'd9);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= ST_LOW;
      dh_q    <= 4'd0;
      dl_q    <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      dh_q    <= dh_d;
      dl_q    <= dl_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    sel_digit = (state_q == ST_HIGH) ? dh_q : dl_q;
    seg_raw   = bcd_to_seg(sel_digit);
    an        = (state_q == ST_HIGH) ? 2'b10 : 2'b01;
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Only the tens digit is ever blanked; the digit enable keeps running.
  assign seg = ((state_q == ST_HIGH) && (dh_q == 4'd0)) ? 7'h00 : seg_raw;
`else
  assign seg = seg_raw;
`endif

  assign err = err_q;

endmodule

// File: tb/tb_bcd_7seg_mux_driver.sv
// Bench for bcd_7seg_mux_driver at REFRESH_DIV=4: vector table, reset/load corner sequences, counter sweeps.
module tb_bcd_7seg_mux_driver;

  localparam int DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZH = 7'h00;
  localparam bit BLANK = 1'b1;
`else
  localparam logic [6:0] ZH = 7'h3F;
  localparam bit BLANK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] high;
  logic [3:0] low;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  always #5 clock = ~clock;

  bcd_7seg_mux_driver #(.REFRESH_DIV(DIV)) dut (
    .clock (clock),
    .reset (reset),
    .high  (high),
    .low   (low),
    .load  (load),
    .seg   (seg),
    .an    (an),
    .err   (err)
  );

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] hi;
    logic [3:0] lo;
    logic [1:0] an;
    logic [6:0] seg;
    logic       err;
  } vec_t;

  typedef struct {
    logic [1:0] an;
    logic [6:0] seg;
    logic       err;
    string      tag;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Independent reference model, advanced once per driven edge.
  logic [6:0] lut [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [3:0] m_dh = 4'd0;
  logic [3:0] m_dl = 4'd0;
  int         m_cnt = 0;
  bit         m_hi = 1'b0;
  logic       m_err = 1'b0;

  function automatic vec_t mk(input logic r, input logic l, input logic [3:0] h, input logic [3:0] lo_i,
                              input logic [1:0] a, input logic [6:0] s, input logic e);
    vec_t v;
    v.rst = r; v.ld = l; v.hi = h; v.lo = lo_i; v.an = a; v.seg = s; v.err = e;
    return v;
  endfunction

  task automatic model_edge(input logic r, input logic l, input logic [3:0] h, input logic [3:0] lo_i);
    if (r) begin
      m_dh = 0; m_dl = 0; m_cnt = 0; m_hi = 0; m_err = 0;
    end else begin
      if (l) begin
        m_dh = h; m_dl = lo_i; m_err = (h > 9) || (lo_i > 9);
      end
      if (m_cnt == DIV - 1) begin
        m_cnt = 0; m_hi = ~m_hi;
      end else begin
        m_cnt++;
      end
    end
  endtask

  function automatic exp_t model_exp(input string tag);
    exp_t e;
    logic [3:0] d;
    d = m_hi ? m_dh : m_dl;
    e.an  = m_hi ? 2'b10 : 2'b01;
    e.err = m_err;
    if (m_hi && BLANK && m_dh == 0) e.seg = 7'h00;
    else if (d > 9)                 e.seg = 7'h40;
    else                            e.seg = lut[d];
    e.tag = tag;
    return e;
  endfunction

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (an !== e.an) begin
      errors++;
      $display("FAIL %s an: got %b required %b", e.tag, an, e.an);
    end
    checks++;
    if (seg !== e.seg) begin
      errors++;
      $display("FAIL %s seg: got %h required %h", e.tag, seg, e.seg);
    end
    checks++;
    if (err !== e.err) begin
      errors++;
      $display("FAIL %s err: got %b required %b", e.tag, err, e.err);
    end
    $display("%s: rst=%b ld=%b hi=%h lo=%h -> an=%b seg=%h err=%b", e.tag, reset, load, high, low, an, seg, err);
  endtask

  // One transaction: drive on negedge, queue the expectation, sample 1 time unit after the edge.
  task automatic cycle(input logic r, input logic l, input logic [3:0] h, input logic [3:0] lo_i,
                       input bit use_tab, input exp_t tab_e, input string tag);
    exp_t e;
    @(negedge clock);
    reset = r; load = l; high = h; low = lo_i;
    model_edge(r, l, h, lo_i);
    if (use_tab) begin
      e = tab_e;
      e.tag = tag;
    end else begin
      e = model_exp(tag);
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  task automatic mcycle(input logic r, input logic l, input logic [3:0] h, input logic [3:0] lo_i, input string tag);
    exp_t dummy;
    dummy.an = 2'b00; dummy.seg = 7'h00; dummy.err = 1'b0; dummy.tag = "";
    cycle(r, l, h, lo_i, 1'b0, dummy, tag);
  endtask

  initial begin
    exp_t te;
    int v;
    reset = 1'b1; load = 1'b0; high = 4'd0; low = 4'd0;

    vq.push_back(mk(1, 0, 4'h0, 4'h0, 2'b01, 7'h3F, 0));
    for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 4'h0, 4'h0, 2'b01, 7'h3F, 0));
    for (int i = 0; i < 4; i++) vq.push_back(mk(0, 0, 4'h0, 4'h0, 2'b10, ZH, 0));
    vq.push_back(mk(0, 1, 4'h5, 4'h9, 2'b01, 7'h6F, 0));
    for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 4'hF, 4'hE, 2'b01, 7'h6F, 0));
    for (int i = 0; i < 4; i++) vq.push_back(mk(0, 0, 4'h1, 4'h2, 2'b10, 7'h6D, 0));
    vq.push_back(mk(0, 1, 4'hC, 4'h3, 2'b01, 7'h4F, 1));
    for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 4'h0, 4'h0, 2'b01, 7'h4F, 1));
    for (int i = 0; i < 4; i++) vq.push_back(mk(0, 0, 4'h0, 4'h0, 2'b10, 7'h40, 1));
    vq.push_back(mk(0, 1, 4'h2, 4'h7, 2'b01, 7'h07, 0));
    vq.push_back(mk(0, 0, 4'hA, 4'hB, 2'b01, 7'h07, 0));
    vq.push_back(mk(0, 1, 4'h0, 4'h0, 2'b01, 7'h3F, 0));
    vq.push_back(mk(0, 0, 4'h9, 4'h9, 2'b01, 7'h3F, 0));
    // Load lands on the wrap edge: new state and new tens digit together.
    vq.push_back(mk(0, 1, 4'h8, 4'h1, 2'b10, 7'h7F, 0));
    for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 4'h3, 4'h3, 2'b10, 7'h7F, 0));
    vq.push_back(mk(0, 0, 4'h0, 4'h0, 2'b01, 7'h06, 0));

    for (int i = 0; i < vq.size(); i++) begin
      te.an = vq[i].an; te.seg = vq[i].seg; te.err = vq[i].err; te.tag = "";
      cycle(vq[i].rst, vq[i].ld, vq[i].hi, vq[i].lo, 1'b1, te, $sformatf("vec%0d", i));
    end

    // Reset together with load while HIGH and counter at 2.
    for (int i = 0; i < 6; i++) mcycle(0, 0, 4'h0, 4'h0, $sformatf("pre_rst%0d", i));
    mcycle(1, 1, 4'h5, 4'h9, "rst_vs_load");
    for (int i = 0; i < 8; i++) mcycle(0, 0, 4'h0, 4'h0, $sformatf("post_rst%0d", i));

    // Mid-LOW reset restarts a full LOW phase.
    mcycle(0, 1, 4'h3, 4'h4, "mid_load");
    mcycle(1, 0, 4'h0, 4'h0, "mid_rst");
    for (int i = 0; i < 5; i++) mcycle(0, 0, 4'h0, 4'h0, $sformatf("mid_post%0d", i));

    for (int k = 0; k <= 60; k++) begin
      v = (59 + k) % 60;
      mcycle(0, 1, 4'(v / 10), 4'(v % 10), $sformatf("up_%02d", v));
    end
    for (int k = 0; k <= 60; k++) begin
      v = (60 - k) % 60;
      mcycle(0, 1, 4'(v / 10), 4'(v % 10), $sformatf("dn_%02d", v));
    end

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
    end
    checks++;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
